lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have no parameters; widths are fixed.
REQ-002 Clk  in  1  sole clock, rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 ReqValid  in  1  request present.
REQ-005 ReqReady  out  1  request accepted when ReqValid&ReqReady at a rising Clk edge.
REQ-006 ReqWr  in  1  1=store, 0=load.
REQ-007 ReqSize  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 ReqSigned  in  1  sign-extend load result.
REQ-009 ReqAddr  in  32  byte address.
REQ-010 ReqWrData  in  32  store data, right-justified.
REQ-011 RespValid  out  1  one-cycle completion pulse, no backpressure.
REQ-012 RespData  out  32  load result; 0 for stores and faults.
REQ-013 RespFault  out  1  misaligned/reserved access, valid with RespValid.
REQ-014 DmAd  out  30  word address to data memory (byte address bits 31:2).
REQ-015 DmWrData  out  32  word written to data memory.
REQ-016 DmWr  out  1  data memory write enable.
REQ-017 DmRd  in  32  data memory read word, registered, valid the cycle after DmAd is presented with DmWr=0.

Function
REQ-018 FSM states: IDLE, RD, MRG, WR, RESP; ReqReady=1 only in IDLE.
REQ-019 On accept, ReqAddr, ReqWr, ReqSize, ReqSigned and ReqWrData SHALL be registered; DmAd SHALL hold the registered address[31:2] until return to IDLE.
REQ-020 Load: IDLE->RD->RESP; accepted at edge ending cycle N -> RespValid in cycle N+2.
REQ-021 Word store: IDLE->WR->RESP; DmWr=1 for exactly the WR cycle with DmWrData=ReqWrData; RespValid in N+2.
REQ-022 Byte/half store: IDLE->RD->MRG->RESP; in MRG DmWr=1 with DmRd merged with the new lane(s); other lanes unchanged; RespValid in N+3.
REQ-023 Little-endian lanes: byte k = bits [8k+7:8k]; byte lane = addr[1:0]; half lane = addr[1].
REQ-024 Load result: selected lane shifted to bit 0, upper bits sign- or zero-extended per ReqSigned; word loads ignore ReqSigned.
REQ-025 RESP SHALL last exactly one cycle then go to IDLE; a new request MAY be accepted the following cycle.
REQ-026 DmWr SHALL be 0 in every state except WR and MRG.
REQ-027 ReqValid while not in IDLE SHALL be ignored (not accepted, not queued).

Reset
REQ-028 Reset SHALL force IDLE immediately: ReqReady=1, RespValid=0, RespData=0, RespFault=0, DmWr=0, DmAd=0, DmWrData=0.
REQ-029 Reset mid-operation SHALL drop the transaction with no response and no later DmWr.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN: when defined, half with addr[0]=1, word with addr[1:0]!=0, or ReqSize=11 SHALL go IDLE->RESP with RespFault=1, RespData=0, no DmWr, RespValid in N+1.
REQ-031 When undefined, RespFault SHALL be tied 0, ignored low address bits SHALL be dropped (half uses addr[1] only, word uses addr[31:2]), and ReqSize=11 SHALL behave as word.

Structure
REQ-032 Shared package lsu_pkg SHALL hold ReqSize encodings and FSM state encoding.
REQ-033 Sub-module lsu_load_align SHALL implement combinational lane select and extension (word, addr[1:0], size, signed -> 32-bit result), reused for merge-mask generation.

Verification
REQ-034 Preload word 0x8000_0010 = 0x89AB_CDEF; load byte signed at 0x8000_0011 -> RespData 0xFFFF_FFCD in N+2.
REQ-035 Same word, load half unsigned at 0x8000_0012 -> RespData 0x0000_89AB; load word -> 0x89AB_CDEF.
REQ-036 Store byte 0x55 at 0x8000_0012 -> single DmWr cycle (N+2) with DmWrData 0x8955_CDEF; RespValid N+3.
REQ-037 Store word 0x1234_5678 at 0x8000_0010 -> DmWr in N+1 only, reload returns 0x1234_5678.
REQ-038 Half load at 0x8000_0011: with LSU_MISALIGN_TRAP_EN -> RespFault=1, RespData 0, no DmWr, N+1; without -> normal data from lane addr[1]=0.
REQ-039 Reset asserted during MRG -> DmWr drops same cycle, no RespValid, memory word unchanged, ReqReady=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-size encodings, FSM state encoding and lane helpers.
// Misalignment helper is only consulted when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_MRG  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  // Byte offset of the addressed lane inside the word; halves use addr[1] only.
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SZ_BYTE)      lane_offset = addr_lo;
    else if (size == SZ_HALF) lane_offset = {addr_lo[1], 1'b0};
    else                      lane_offset = 2'b00;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    is_misaligned = (size == SZ_HALF && addr_lo[0]) ||
                    (size == SZ_WORD && addr_lo != 2'b00) ||
                    (size == SZ_RSVD);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// LSU request/response and data-memory bundle; the LSU sits on the slave modport.
// Request handshake: a request transfers on a rising Clk edge where ReqValid && ReqReady;
// responses are one-cycle RespValid pulses with no backpressure.
interface lsu_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWr;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWrData;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespFault;
  logic [29:0] DmAd;
  logic [31:0] DmWrData;
  logic        DmWr;
  logic [31:0] DmRd;

  modport master (
    output ReqValid, ReqWr, ReqSize, ReqSigned, ReqAddr, ReqWrData, DmRd,
    input  ReqReady, RespValid, RespData, RespFault, DmAd, DmWrData, DmWr
  );

  modport slave (
    input  ReqValid, ReqWr, ReqSize, ReqSigned, ReqAddr, ReqWrData, DmRd,
    output ReqReady, RespValid, RespData, RespFault, DmAd, DmWrData, DmWr
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational lane select and sign/zero extension of a memory word.
// Fed with an all-ones word and is_signed=0 it yields the lane-width mask at bit 0.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);
  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane_offset(size, addr_lo), 3'b000};
    case (size)
      SZ_BYTE: result = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: result = word;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, byte/half stores done as read-merge-write.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned/reserved accesses into faults.
module lsu
  import lsu_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  lsu_if.slave       bus,
  output lsu_state_e dbg_state
);
  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        signed_q, signed_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        fault_q, fault_d;
`endif
  logic [31:0] load_res, lane_mask, merge_mask, merged;
  logic [4:0]  lane_shift;
  logic        resp_load;

  lsu_load_align u_load (
    .word(bus.DmRd), .addr_lo(addr_q[1:0]), .size(size_q),
    .is_signed(signed_q), .result(load_res)
  );

  lsu_load_align u_mask (
    .word(32'hFFFF_FFFF), .addr_lo(addr_q[1:0]), .size(size_q),
    .is_signed(1'b0), .result(lane_mask)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    wr_d     = wr_q;
    signed_d = signed_q;
`ifdef LSU_MISALIGN_TRAP_EN
    fault_d  = fault_q;
`endif
    case (state_q)
      ST_IDLE: if (bus.ReqValid) begin
        addr_d   = bus.ReqAddr;
        wdata_d  = bus.ReqWrData;
        size_d   = bus.ReqSize;
        wr_d     = bus.ReqWr;
        signed_d = bus.ReqSigned;
`ifdef LSU_MISALIGN_TRAP_EN
        fault_d  = is_misaligned(bus.ReqSize, bus.ReqAddr[1:0]);
        if (fault_d) state_d = ST_RESP; else
`endif
        // Sizes 10 and 11 both store a full word without a read.
        if (bus.ReqWr && bus.ReqSize[1]) state_d = ST_WR;
        else                             state_d = ST_RD;
      end
      ST_RD:   state_d = wr_q ? ST_MRG : ST_RESP;
      ST_MRG:  state_d = ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 2'b00;
      wr_q     <= 1'b0;
      signed_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      signed_q <= signed_d;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q  <= fault_d;
`endif
    end
  end

  // Merge the new lane(s) into the word read back during RD.
  assign lane_shift = {lane_offset(size_q, addr_q[1:0]), 3'b000};
  assign merge_mask = lane_mask << lane_shift;
  assign merged     = (bus.DmRd & ~merge_mask) | ((wdata_q & lane_mask) << lane_shift);

`ifdef LSU_MISALIGN_TRAP_EN
  assign resp_load     = (state_q == ST_RESP) && !wr_q && !fault_q;
  assign bus.RespFault = (state_q == ST_RESP) && fault_q;
`else
  assign resp_load     = (state_q == ST_RESP) && !wr_q;
  assign bus.RespFault = 1'b0;
`endif

  assign bus.ReqReady  = (state_q == ST_IDLE);
  assign bus.RespValid = (state_q == ST_RESP);
  assign bus.RespData  = resp_load ? load_res : 32'h0;
  assign bus.DmAd      = addr_q[31:2];
  assign bus.DmWr      = (state_q == ST_WR) || (state_q == ST_MRG);
  assign bus.DmWrData  = (state_q == ST_WR)  ? wdata_q :
                         (state_q == ST_MRG) ? merged  : 32'h0;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: small registered memory model, per-feature test tasks, one summary.
module tb_lsu;
  import lsu_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  lsu_if      bus ();
  lsu_state_e dbg_state;

  lsu dut (.Clk(Clk), .Reset(Reset), .bus(bus), .dbg_state(dbg_state));

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          wr_cyc = 0;
  logic [31:0] wr_data = 32'h0;
  logic [31:0] mem [16];
  logic        preload_en = 1'b0;
  logic [3:0]  preload_idx = 4'h0;
  logic [31:0] preload_data = 32'h0;

  // Registered data memory: read data valid the cycle after DmAd.
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (preload_en) mem[preload_idx] <= preload_data;
    else if (bus.DmWr === 1'b1) begin
      mem[bus.DmAd[3:0]] <= bus.DmWrData;
      wr_count <= wr_count + 1;
      wr_cyc   <= cyc;
      wr_data  <= bus.DmWrData;
    end
    bus.DmRd <= mem[bus.DmAd[3:0]];
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge Clk);
    preload_en = 1'b1; preload_idx = idx; preload_data = data;
    @(negedge Clk);
    preload_en = 1'b0;
  endtask

  task automatic do_op(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] data, output logic flt,
                       output int nwr, output int wlat, output logic [31:0] wd);
    int n0, w0;
    bit seen;
    @(negedge Clk);
    n_vec++;
    if (bus.ReqReady !== 1'b1) begin
      n_err++; $display("FAIL op_ready_idle: got %b want 1", bus.ReqReady);
    end
    bus.ReqValid = 1'b1; bus.ReqWr = wr; bus.ReqSize = size; bus.ReqSigned = sgn;
    bus.ReqAddr = addr; bus.ReqWrData = wdata;
    n0 = cyc; w0 = wr_count;
    @(negedge Clk);
    bus.ReqValid = 1'b0;
    seen = 0; lat = -1; data = 32'h0; flt = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (bus.RespValid === 1'b1) begin
        seen = 1; lat = cyc - n0; data = bus.RespData; flt = bus.RespFault;
      end else @(negedge Clk);
    end
    nwr = wr_count - w0; wlat = wr_cyc - n0; wd = wr_data;
  endtask

  int lat, nwr, wlat;
  logic [31:0] data, wd;
  logic flt;

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge Clk);
    n_vec += 8;
    if (bus.ReqReady !== 1'b1)    begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.ReqReady); end
    if (bus.RespValid !== 1'b0)   begin n_err++; $display("FAIL rst_respvalid: got %b want 0", bus.RespValid); end
    if (bus.RespData !== 32'h0)   begin n_err++; $display("FAIL rst_respdata: got %h want 0", bus.RespData); end
    if (bus.RespFault !== 1'b0)   begin n_err++; $display("FAIL rst_fault: got %b want 0", bus.RespFault); end
    if (bus.DmWr !== 1'b0)        begin n_err++; $display("FAIL rst_dmwr: got %b want 0", bus.DmWr); end
    if (bus.DmAd !== 30'h0)       begin n_err++; $display("FAIL rst_dmad: got %h want 0", bus.DmAd); end
    if (bus.DmWrData !== 32'h0)   begin n_err++; $display("FAIL rst_dmwrdata: got %h want 0", bus.DmWrData); end
    if (dbg_state !== ST_IDLE)    begin n_err++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_load();
    preload(4'd4, 32'h89AB_CDEF);
    do_op(1'b0, SZ_BYTE, 1'b1, 32'h8000_0011, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec += 4;
    if (data !== 32'hFFFF_FFCD) begin n_err++; $display("FAIL ld_byte_s_data: got %h want ffffffcd", data); end
    if (lat != 2)               begin n_err++; $display("FAIL ld_byte_s_lat: got %0d want 2", lat); end
    if (flt !== 1'b0)           begin n_err++; $display("FAIL ld_byte_s_fault: got %b want 0", flt); end
    if (nwr != 0)               begin n_err++; $display("FAIL ld_byte_s_nowr: got %0d want 0", nwr); end
    do_op(1'b0, SZ_HALF, 1'b0, 32'h8000_0012, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec += 2;
    if (data !== 32'h0000_89AB) begin n_err++; $display("FAIL ld_half_u_data: got %h want 000089ab", data); end
    if (lat != 2)               begin n_err++; $display("FAIL ld_half_u_lat: got %0d want 2", lat); end
    do_op(1'b0, SZ_HALF, 1'b1, 32'h8000_0012, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec++;
    if (data !== 32'hFFFF_89AB) begin n_err++; $display("FAIL ld_half_s_data: got %h want ffff89ab", data); end
    do_op(1'b0, SZ_BYTE, 1'b0, 32'h8000_0013, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec++;
    if (data !== 32'h0000_0089) begin n_err++; $display("FAIL ld_byte_u_data: got %h want 00000089", data); end
    do_op(1'b0, SZ_WORD, 1'b1, 32'h8000_0010, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec += 2;
    if (data !== 32'h89AB_CDEF) begin n_err++; $display("FAIL ld_word_data: got %h want 89abcdef", data); end
    if (lat != 2)               begin n_err++; $display("FAIL ld_word_lat: got %0d want 2", lat); end
  endtask

  task automatic test_store_sub();
    do_op(1'b1, SZ_BYTE, 1'b0, 32'h8000_0012, 32'h0000_0055, lat, data, flt, nwr, wlat, wd);
    n_vec += 5;
    if (nwr != 1)               begin n_err++; $display("FAIL st_byte_nwr: got %0d want 1", nwr); end
    if (wlat != 2)              begin n_err++; $display("FAIL st_byte_wlat: got %0d want 2", wlat); end
    if (wd !== 32'h8955_CDEF)   begin n_err++; $display("FAIL st_byte_wdata: got %h want 8955cdef", wd); end
    if (lat != 3)               begin n_err++; $display("FAIL st_byte_lat: got %0d want 3", lat); end
    if (data !== 32'h0)         begin n_err++; $display("FAIL st_byte_respdata: got %h want 0", data); end
    do_op(1'b1, SZ_HALF, 1'b0, 32'h8000_0010, 32'h0000_BEEF, lat, data, flt, nwr, wlat, wd);
    n_vec += 3;
    if (nwr != 1)               begin n_err++; $display("FAIL st_half_nwr: got %0d want 1", nwr); end
    if (wd !== 32'h8955_BEEF)   begin n_err++; $display("FAIL st_half_wdata: got %h want 8955beef", wd); end
    if (lat != 3)               begin n_err++; $display("FAIL st_half_lat: got %0d want 3", lat); end
    do_op(1'b0, SZ_WORD, 1'b0, 32'h8000_0010, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec++;
    if (data !== 32'h8955_BEEF) begin n_err++; $display("FAIL st_sub_reload: got %h want 8955beef", data); end
  endtask

  task automatic test_store_word();
    do_op(1'b1, SZ_WORD, 1'b0, 32'h8000_0010, 32'h1234_5678, lat, data, flt, nwr, wlat, wd);
    n_vec += 4;
    if (nwr != 1)               begin n_err++; $display("FAIL st_word_nwr: got %0d want 1", nwr); end
    if (wlat != 1)              begin n_err++; $display("FAIL st_word_wlat: got %0d want 1", wlat); end
    if (wd !== 32'h1234_5678)   begin n_err++; $display("FAIL st_word_wdata: got %h want 12345678", wd); end
    if (lat != 2)               begin n_err++; $display("FAIL st_word_lat: got %0d want 2", lat); end
    do_op(1'b0, SZ_WORD, 1'b0, 32'h8000_0010, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec++;
    if (data !== 32'h1234_5678) begin n_err++; $display("FAIL st_word_reload: got %h want 12345678", data); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_half, exp_word;
    logic        exp_flt;
    int          exp_lat;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_half = 32'h0; exp_word = 32'h0; exp_flt = 1'b1; exp_lat = 1;
`else
    exp_half = 32'h0000_5678; exp_word = 32'h1234_5678; exp_flt = 1'b0; exp_lat = 2;
`endif
    do_op(1'b0, SZ_HALF, 1'b0, 32'h8000_0011, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec += 4;
    if (data !== exp_half)      begin n_err++; $display("FAIL mis_half_data: got %h want %h", data, exp_half); end
    if (flt !== exp_flt)        begin n_err++; $display("FAIL mis_half_fault: got %b want %b", flt, exp_flt); end
    if (lat != exp_lat)         begin n_err++; $display("FAIL mis_half_lat: got %0d want %0d", lat, exp_lat); end
    if (nwr != 0)               begin n_err++; $display("FAIL mis_half_nowr: got %0d want 0", nwr); end
    do_op(1'b0, SZ_WORD, 1'b0, 32'h8000_0013, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec += 2;
    if (data !== exp_word)      begin n_err++; $display("FAIL mis_word_data: got %h want %h", data, exp_word); end
    if (flt !== exp_flt)        begin n_err++; $display("FAIL mis_word_fault: got %b want %b", flt, exp_flt); end
    do_op(1'b1, SZ_RSVD, 1'b0, 32'h8000_0010, 32'hCAFE_F00D, lat, data, flt, nwr, wlat, wd);
    n_vec += 2;
`ifdef LSU_MISALIGN_TRAP_EN
    if (nwr != 0)               begin n_err++; $display("FAIL rsvd_st_nwr: got %0d want 0", nwr); end
    if (flt !== 1'b1)           begin n_err++; $display("FAIL rsvd_st_fault: got %b want 1", flt); end
`else
    if (nwr != 1 || wd !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rsvd_st_word: got %0d/%h want 1/cafef00d", nwr, wd); end
    if (lat != 2)               begin n_err++; $display("FAIL rsvd_st_lat: got %0d want 2", lat); end
    preload(4'd4, 32'h1234_5678);
`endif
  endtask

  task automatic test_busy_ignore();
    int w0;
    @(negedge Clk);
    bus.ReqValid = 1'b1; bus.ReqWr = 1'b0; bus.ReqSize = SZ_WORD; bus.ReqSigned = 1'b0;
    bus.ReqAddr = 32'h8000_0010; bus.ReqWrData = 32'h0;
    w0 = wr_count;
    @(negedge Clk);
    bus.ReqWr = 1'b1; bus.ReqWrData = 32'hDEAD_BEEF;
    n_vec += 2;
    if (bus.ReqReady !== 1'b0)  begin n_err++; $display("FAIL busy_ready_rd: got %b want 0", bus.ReqReady); end
    if (dbg_state !== ST_RD)    begin n_err++; $display("FAIL busy_state_rd: got %0d want %0d", dbg_state, ST_RD); end
    @(negedge Clk);
    n_vec += 2;
    if (bus.RespValid !== 1'b1) begin n_err++; $display("FAIL busy_resp: got %b want 1", bus.RespValid); end
    if (bus.RespData !== 32'h1234_5678) begin n_err++; $display("FAIL busy_data: got %h want 12345678", bus.RespData); end
    bus.ReqValid = 1'b0;
    @(negedge Clk);
    n_vec += 2;
    if (bus.RespValid !== 1'b0) begin n_err++; $display("FAIL busy_resp_once: got %b want 0", bus.RespValid); end
    if (wr_count != w0)         begin n_err++; $display("FAIL busy_nowr: got %0d want %0d", wr_count, w0); end
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, SZ_BYTE, 1'b0, 32'h8000_0010, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec++;
    if (data !== 32'h0000_0078) begin n_err++; $display("FAIL b2b_first: got %h want 00000078", data); end
    do_op(1'b0, SZ_HALF, 1'b1, 32'h8000_0012, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec += 2;
    if (data !== 32'h0000_1234) begin n_err++; $display("FAIL b2b_second: got %h want 00001234", data); end
    if (lat != 2)               begin n_err++; $display("FAIL b2b_lat: got %0d want 2", lat); end
  endtask

  task automatic test_reset_mrg();
    int  w0;
    bit  resp_seen;
    @(negedge Clk);
    bus.ReqValid = 1'b1; bus.ReqWr = 1'b1; bus.ReqSize = SZ_BYTE; bus.ReqSigned = 1'b0;
    bus.ReqAddr = 32'h8000_0013; bus.ReqWrData = 32'h0000_00AA;
    w0 = wr_count;
    @(negedge Clk);
    bus.ReqValid = 1'b0;
    @(negedge Clk);
    n_vec++;
    if (bus.DmWr !== 1'b1)      begin n_err++; $display("FAIL rmrg_in_mrg: got %b want 1", bus.DmWr); end
    Reset = 1'b1;
    #1;
    n_vec += 4;
    if (bus.DmWr !== 1'b0)      begin n_err++; $display("FAIL rmrg_dmwr: got %b want 0", bus.DmWr); end
    if (bus.ReqReady !== 1'b1)  begin n_err++; $display("FAIL rmrg_ready: got %b want 1", bus.ReqReady); end
    if (bus.RespValid !== 1'b0) begin n_err++; $display("FAIL rmrg_resp: got %b want 0", bus.RespValid); end
    if (bus.DmWrData !== 32'h0) begin n_err++; $display("FAIL rmrg_wdata: got %h want 0", bus.DmWrData); end
    resp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (i == 1) Reset = 1'b0;
      if (bus.RespValid === 1'b1) resp_seen = 1;
    end
    n_vec += 2;
    if (resp_seen)              begin n_err++; $display("FAIL rmrg_no_resp: got 1 want 0"); end
    if (wr_count != w0)         begin n_err++; $display("FAIL rmrg_nowr: got %0d want %0d", wr_count, w0); end
    do_op(1'b0, SZ_WORD, 1'b0, 32'h8000_0010, 32'h0, lat, data, flt, nwr, wlat, wd);
    n_vec++;
    if (data !== 32'h1234_5678) begin n_err++; $display("FAIL rmrg_mem: got %h want 12345678", data); end
  endtask

  initial begin
    bus.ReqValid = 1'b0; bus.ReqWr = 1'b0; bus.ReqSize = 2'b00; bus.ReqSigned = 1'b0;
    bus.ReqAddr = 32'h0; bus.ReqWrData = 32'h0;
    #2;
    test_reset();
    test_load();
    test_store_sub();
    test_store_word();
    test_misalign();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mrg();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
